// File: rtl/cache_pkg.sv
// Shared definitions for the LRU replacement engine: width helper,
// default geometry and the way/age types for the default configuration.
package cache_pkg;

    // Ceiling log2 usable in constant expressions; returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    localparam int DEF_NUM_WAYS = 4;
    localparam int DEF_NUM_SETS = 4;

    typedef logic [clog2(DEF_NUM_WAYS)-1:0] way_idx_t;
    typedef logic [clog2(DEF_NUM_WAYS)-1:0] age_t;

    localparam age_t AGE_MRU = age_t'(DEF_NUM_WAYS - 1);

endpackage

// File: rtl/lru_set_ages.sv
// Age registers for one cache set. Age 0 marks the LRU way and
// NUM_WAYS-1 the MRU way; updates keep the ages a permutation.
module lru_set_ages
    import cache_pkg::*;
#(
    parameter  int NUM_WAYS = DEF_NUM_WAYS,
    localparam int WAY_W    = clog2(NUM_WAYS)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               do_acc,
    input  logic                               acc_hit,
    input  logic [WAY_W-1:0]                   acc_way,
    input  logic                               do_inv,
    input  logic [WAY_W-1:0]                   inv_way,
    output logic [WAY_W-1:0]                   lru_way,
    output logic [NUM_WAYS-1:0][WAY_W-1:0]     ages
);

    localparam logic [WAY_W-1:0] MRU_AGE = WAY_W'(NUM_WAYS - 1);

    logic [WAY_W-1:0]               target;
    logic [WAY_W-1:0]               cur;
    logic [NUM_WAYS-1:0][WAY_W-1:0] ages_next;

    // Locate the age-0 way; scanning downward lets the lowest index win.
    always_comb begin
        lru_way = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (ages[i] == '0) lru_way = WAY_W'(i);
        end
    end

    // Access promotes the target to MRU and closes the gap above it;
    // invalidate demotes a way to LRU and shifts the younger ways up.
    always_comb begin
        target    = acc_hit ? acc_way : lru_way;
        cur       = '0;
        ages_next = ages;
        if (do_acc) begin
            cur = ages[target];
            for (int i = 0; i < NUM_WAYS; i++) begin
                if (WAY_W'(i) == target)  ages_next[i] = MRU_AGE;
                else if (ages[i] > cur)   ages_next[i] = ages[i] - 1'b1;
            end
        end else if (do_inv) begin
            cur = ages[inv_way];
            for (int i = 0; i < NUM_WAYS; i++) begin
                if (WAY_W'(i) == inv_way) ages_next[i] = '0;
                else if (ages[i] < cur)   ages_next[i] = ages[i] + 1'b1;
            end
        end
    end

    // Age state; reset gives way i age i so way 0 starts as the victim.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_WAYS; i++) ages[i] <= WAY_W'(i);
        end else begin
            ages <= ages_next;
        end
    end

endmodule

// File: rtl/lru_age_policy.sv
// Multi-set counter-based LRU engine: set decode, access/invalidate
// conflict resolution, victim query and registered reporting.
module lru_age_policy
    import cache_pkg::*;
#(
    parameter  int NUM_WAYS = DEF_NUM_WAYS,
    parameter  int NUM_SETS = DEF_NUM_SETS,
    localparam int WAY_W    = clog2(NUM_WAYS),
    localparam int SET_W    = (NUM_SETS > 1) ? clog2(NUM_SETS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             acc_valid,
    input  logic [SET_W-1:0] acc_set,
    input  logic             acc_hit,
    input  logic [WAY_W-1:0] acc_way,
    output logic             fill_valid,
    output logic [WAY_W-1:0] fill_way,
    input  logic             inv_valid,
    input  logic [SET_W-1:0] inv_set,
    input  logic [WAY_W-1:0] inv_way,
    output logic             inv_drop,
    input  logic [SET_W-1:0] query_set,
    output logic [WAY_W-1:0] victim_way
);

    logic [NUM_SETS-1:0]                          do_acc;
    logic [NUM_SETS-1:0]                          do_inv;
    logic [WAY_W-1:0]                             lru_ways [NUM_SETS];
    logic [NUM_SETS-1:0][NUM_WAYS-1:0][WAY_W-1:0] set_ages;
    logic                                         conflict;
    logic [WAY_W-1:0]                             acc_target;
    logic [NUM_WAYS-1:0][WAY_W-1:0]               q_ages;
    logic [WAY_W-1:0]                             victim_next;

    // An access wins over an invalidate aimed at the same set.
    assign conflict = acc_valid && inv_valid && (acc_set == inv_set);

    for (genvar s = 0; s < NUM_SETS; s++) begin : g_set
        assign do_acc[s] = acc_valid && (acc_set == SET_W'(s));
        assign do_inv[s] = inv_valid && (inv_set == SET_W'(s)) && !conflict;

        lru_set_ages #(.NUM_WAYS(NUM_WAYS)) u_set (
            .clk     (clk),
            .reset   (reset),
            .do_acc  (do_acc[s]),
            .acc_hit (acc_hit),
            .acc_way (acc_way),
            .do_inv  (do_inv[s]),
            .inv_way (inv_way),
            .lru_way (lru_ways[s]),
            .ages    (set_ages[s])
        );
    end

    // Resolve the way an access makes MRU, and encode the queried set's victim.
    always_comb begin
        acc_target  = acc_hit ? acc_way : lru_ways[acc_set];
        q_ages      = set_ages[query_set];
        victim_next = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (q_ages[i] == '0) victim_next = WAY_W'(i);
        end
    end

    // Registered reports; fill_way keeps its last value between accesses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_valid <= 1'b0;
            fill_way   <= '0;
            inv_drop   <= 1'b0;
            victim_way <= '0;
        end else begin
            fill_valid <= acc_valid;
            if (acc_valid) fill_way <= acc_target;
            inv_drop   <= conflict;
            victim_way <= victim_next;
        end
    end

endmodule
